// File: rtl/polyline_scheduler.sv
// Double-buffered command scheduler for the polyline draw engine.
// Two command slots (one per point-buffer bank) are filled from the SPI side
// and drained by a launch/wait/draw/release sequence towards the engine.
module polyline_scheduler #(
  parameter int C_LEN_BITS = 10,
  parameter int C_TIMEOUT  = 15
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_wr,
  input  logic [15:0]           cmd_color,
  input  logic [C_LEN_BITS-1:0] cmd_len,
  input  logic                  abort,
  input  logic                  busy_in,
  output logic                  plot,
  output logic [15:0]           color,
  output logic [C_LEN_BITS-1:0] len,
  output logic                  wr_bank,
  output logic                  rd_bank,
  output logic                  host_busy,
  output logic                  cmd_drop,
  output logic [15:0]           done_cnt
);

  // Last WAIT_RISE timer value before giving up on busy_in. The timer holds
  // the number of cycles since plot, so the release lands C_TIMEOUT cycles
  // after plot (never earlier than the first WAIT_RISE cycle).
  localparam int TO_LAST = (C_TIMEOUT > 1) ? (C_TIMEOUT - 1) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_RISE = 3'd2,
    DRAW      = 3'd3,
    RELEASE   = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  // Per-bank command slots; payload is plain data and carries no reset
  logic [1:0]            slot_vld;
  logic [1:0]            slot_vld_nxt;
  logic [15:0]           slot_color [2];
  logic [C_LEN_BITS-1:0] slot_len   [2];

  logic [3:0] timer;

  logic full;
  logic rd_vld;
  logic accept;
  logic reject;
  logic release_now;
  logic timeout_hit;
  logic load_cmd;

  assign full        = &slot_vld;
  assign rd_vld      = slot_vld[rd_bank];
  // abort swallows a same-cycle cmd_wr entirely, including the drop pulse
  assign accept      = cmd_wr & ~full & ~abort;
  assign reject      = cmd_wr &  full & ~abort;
  assign release_now = (state == RELEASE) & ~abort;
  assign timeout_hit = (timer >= 4'(TO_LAST));
  assign load_cmd    = (state == IDLE) & (state_nxt == LAUNCH);

  // Next-state decode; abort overrides every transition and forces IDLE
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (rd_vld) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        state_nxt = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (busy_in)          state_nxt = DRAW;
        else if (timeout_hit) state_nxt = RELEASE;
      end
      DRAW: begin
        if (!busy_in) state_nxt = RELEASE;
      end
      RELEASE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Slot occupancy: release frees the read slot, accept fills the write slot.
  // With one slot occupied the banks differ, so both can happen together.
  always_comb begin
    slot_vld_nxt = slot_vld;
    if (abort) begin
      slot_vld_nxt = 2'b00;
    end else begin
      if (release_now) slot_vld_nxt[rd_bank] = 1'b0;
      if (accept)      slot_vld_nxt[wr_bank] = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Bank pointers, occupancy and host-side status flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot_vld  <= 2'b00;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      host_busy <= 1'b0;
      cmd_drop  <= 1'b0;
    end else begin
      slot_vld  <= slot_vld_nxt;
      wr_bank   <= wr_bank ^ accept;
      rd_bank   <= abort ? wr_bank : (rd_bank ^ release_now);
      host_busy <= &slot_vld_nxt;
      cmd_drop  <= reject;
    end
  end

  // Command payload capture into the slot addressed by wr_bank
  always_ff @(posedge clk) begin
    if (accept) begin
      slot_color[wr_bank] <= cmd_color;
      slot_len[wr_bank]   <= cmd_len;
    end
  end

  // Engine-facing outputs: plot pulse and the active command held until release
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      plot  <= 1'b0;
      color <= '0;
      len   <= '0;
    end else begin
      plot <= (state_nxt == LAUNCH);
      if (load_cmd) begin
        color <= slot_color[rd_bank];
        len   <= slot_len[rd_bank];
      end
    end
  end

  // Cycles-since-plot timer used to bound the wait for busy_in
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer <= 4'd0;
    end else if (state == LAUNCH) begin
      timer <= 4'd1;
    end else if (state == WAIT_RISE) begin
      timer <= timer + 4'd1;
    end
  end

  // Completed-command counter, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) done_cnt <= 16'd0;
    else         done_cnt <= done_cnt + 16'(release_now);
  end

endmodule

// File: doc/polyline_scheduler.md
POLYLINE_SCHEDULER -- requirements
Module: polyline_scheduler

Interface
REQ-001 Parameter C_LEN_BITS, default 10, width of the command length field (point-buffer words).
REQ-002 Parameter C_TIMEOUT, default 15, maximum cycles from plot to busy_in rising before the launch is treated as complete (range 1..15).
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 resetn  in  1  asynchronous active-low reset.
REQ-005 cmd_wr  in  1  one-cycle commit strobe from SPI register decode; the current wr_bank is full and ready to draw.
REQ-006 cmd_color  in  16  RGB565 color sampled with cmd_wr.
REQ-007 cmd_len  in  C_LEN_BITS  length sampled with cmd_wr.
REQ-008 abort  in  1  synchronous flush request.
REQ-009 busy_in  in  1  busy from the polyline draw engine.
REQ-010 plot  out  1  one-cycle start pulse to the draw engine.
REQ-011 color  out  16  color of the active command, stable from plot until release.
REQ-012 len  out  C_LEN_BITS  length of the active command, stable from plot until release.
REQ-013 wr_bank  out  1  buffer bank selected for SPI writes (buffer address MSB).
REQ-014 rd_bank  out  1  buffer bank selected for engine reads.
REQ-015 host_busy  out  1  high while no bank is free; forwarded to the ESP32.
REQ-016 cmd_drop  out  1  one-cycle pulse when a cmd_wr is rejected.
REQ-017 done_cnt  out  16  count of completed commands, wraps 0xFFFF->0x0000.

Function
REQ-018 Two command slots shall exist, one per bank, each holding color, len and a valid flag; count = number of valid slots (0..2).
REQ-019 On cmd_wr with count<2 (value before this edge), the slot for wr_bank shall capture cmd_color/cmd_len, become valid, and wr_bank shall toggle on the same edge.
REQ-020 On cmd_wr with count==2, the command shall be ignored, no state shall change, and cmd_drop shall pulse on the following cycle.
REQ-021 host_busy shall be registered and equal (count==2) after each edge.
REQ-022 The FSM states shall be IDLE, LAUNCH, WAIT_RISE, DRAW, RELEASE.
REQ-023 IDLE->LAUNCH when the rd_bank slot is valid; otherwise remain in IDLE.
REQ-024 In LAUNCH, color/len shall load from the rd_bank slot, plot shall be high for exactly this one cycle, and the next state shall be WAIT_RISE.
REQ-025 WAIT_RISE->DRAW when busy_in==1; WAIT_RISE->RELEASE when the timeout counter reaches C_TIMEOUT with busy_in still 0.
REQ-026 DRAW->RELEASE when busy_in==0.
REQ-027 In RELEASE, the rd_bank slot shall be invalidated, rd_bank shall toggle, done_cnt shall increment by 1, and the next state shall be IDLE.
REQ-028 Latency: cmd_wr at edge N into an idle, empty scheduler shall give LAUNCH, and therefore plot high, in the cycle after edge N+1.
REQ-029 cmd_wr and RELEASE in the same cycle shall both take effect: the slot count is unchanged, and acceptance is judged on count before the edge.
REQ-030 Back-to-back: if the other slot is valid at RELEASE, IDLE shall last exactly one cycle before the next LAUNCH.
REQ-031 abort shall invalidate both slots, force the FSM to IDLE, and set rd_bank=wr_bank; done_cnt is unchanged, and a cmd_wr in the same cycle is discarded without a cmd_drop pulse.
REQ-032 abort during DRAW shall not wait for busy_in; the engine is expected to be reset externally.
REQ-033 wr_bank shall never equal rd_bank while count==1 and the FSM is out of IDLE.

Reset
REQ-034 While resetn==0: state=IDLE; slots invalid; wr_bank=0; rd_bank=0; plot=0; cmd_drop=0; host_busy=0; color=0; len=0; done_cnt=0.
REQ-035 Reset asserted mid-draw shall take effect immediately and asynchronously; after deassertion the first command shall use bank 0.

Verification
REQ-036 Single command: cmd_wr with color=0xF800, len=8; busy_in high 20 cycles after plot -> plot 2 cycles after cmd_wr, color=0xF800, len=8, wr_bank=1, done_cnt=1, rd_bank=1.
REQ-037 Double buffer: two cmd_wr 3 cycles apart, busy_in held 50 cycles -> host_busy=1 after the second; a third cmd_wr gives cmd_drop pulse; second plot exactly 2 cycles after the first RELEASE.
REQ-038 Timeout: cmd_wr with busy_in tied 0 -> RELEASE C_TIMEOUT cycles after plot, done_cnt=1, no hang.
REQ-039 Simultaneous: cmd_wr on the RELEASE cycle with count==2 -> rejected with cmd_drop; with count==1 -> accepted, count stays 1, next plot follows.
REQ-040 Abort in DRAW with both slots valid -> IDLE next cycle, host_busy=0, rd_bank==wr_bank, no further plot.
REQ-041 Reset mid-draw -> all outputs at their REQ-034 values asynchronously; new cmd_wr after release draws from bank 0.
